if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction-fetch front end between the instruction memory bus (IAD/IDT/ACKI_n) and the IF/ID pipeline register of the 32I core. It generates sequential fetch addresses and holds one bus request stable through memory wait states. Returned instructions are buffered with their PC in a small queue, so ID-stage stalls do not stop the bus. A taken branch or jump redirects fetch, flushes the queue, and discards any in-flight wrong-path return.

## Interface
- DEPTH, 4: queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- IAD  out  32  fetch address; stable while IREQ=1 and not acknowledged
- IREQ  out  1  fetch request, active high
- IDT  in  32  instruction data; valid when ACKI_n=0
- ACKI_n  in  1  memory acknowledge, active low; sampled at posedge
- redirect  in  1  one-cycle pulse: branch taken or jump (from EX)
- redirect_addr  in  32  new fetch target; bits [1:0] forced to 0
- inst_ready  in  1  IF/ID accepts head entry this cycle (low on stall)
- inst_valid  out  1  head entry valid
- inst  out  32  head instruction (32'h0000_0013 NOP when empty)
- inst_pc  out  32  head PC
- inst_pc4  out  32  head PC + 4 (mod 2^32)
- queue_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FSM states: IDLE, REQ, DISCARD.
- IDLE: IREQ=0. Go to REQ when `count + 0 < DEPTH`, i.e. a free slot exists.
- REQ: IREQ=1, IAD=fetch_pc.
  - ACKI_n=0 pushes {fetch_pc, IDT} and sets fetch_pc += 4.
  - After the push, stay in REQ if the space check (count after push/pop < DEPTH) passes; otherwise go to IDLE.
- DISCARD: IREQ=1 and IAD holds the old wrong-path address, because the bus cannot abort a request. On ACKI_n=0, drop the data and go to REQ with the redirect target.
- Pop: when inst_valid && inst_ready, the head advances at the edge.
- Push and pop in the same cycle: count unchanged. A push is never lost, because a request is issued only when a slot is guaranteed.
- Redirect behaviour:
  - Queue count goes to 0; any same-cycle pop is ignored.
  - fetch_pc is set to {redirect_addr[31:2], 2'b00}.
  - If REQ with ACKI_n=1, go to DISCARD.
  - If REQ with ACKI_n=0 in the same cycle, drop the acked data and go to REQ with the new address; no DISCARD.
  - If IDLE or DISCARD, go to REQ with the new address, or stay in DISCARD if the old ack is still pending. The latest redirect wins.
- Pointer wrap-around is modulo DEPTH. fetch_pc wraps at 2^32.
- Reset values: state IDLE, IREQ=0, IAD=RESET_PC, inst_valid=0, inst=NOP, inst_pc=0, inst_pc4=4, queue_count=0, fetch_pc=RESET_PC.

## Timing
- First IREQ=1 is in the first cycle after rst deasserts.
- Ack sampled at edge N: the entry is visible on inst_* from edge N (registered storage, no IDT→inst bypass). IAD shows the next address from edge N.
- Throughput: with zero-wait memory and continuous inst_ready, one instruction per cycle sustained.
- Redirect at edge N (no pending ack): IAD=target and IREQ=1 from edge N. The first target instruction is valid one edge after its ack.
- rst asserted mid-transaction: immediate return to reset values. The in-flight ack is ignored.

## Structure
- Shared package/header constants:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DISCARD=2'd2).
  - NOP encoding 32'h0000_0013.
  - Default RESET_PC.
- Sub-module fetch_fifo: synchronous DEPTH×64 FIFO of {pc, inst}.
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push and pop.
- Top level keeps the FSM, fetch_pc, and redirect/discard logic.

## Test plan
- Reset, zero-wait memory, inst_ready=1 → IAD 0,4,8,…; inst_pc follows one cycle behind; one instruction per cycle.
- 2-wait-state memory → IAD held for 3 cycles per fetch; each instruction pushed exactly once.
- inst_ready=0 for 10 cycles with DEPTH=4 → queue_count saturates at 4 and IREQ=0. Release → entries drain in order 0,4,8,12 with no loss or duplication.
- Redirect to 0x100 while a request to 0x10 waits 2 cycles → DISCARD holds IAD=0x10; its data is dropped; next IAD=0x100; first inst_pc=0x100.
- Redirect coincident with ACKI_n=0 and inst_ready=1 → acked data dropped, no DISCARD, queue_count=0, IAD=target next cycle.
- rst low mid-wait-state → all outputs at reset values. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding,
// the NOP word presented when the queue is empty, and queue entry layout.
package if_fetch_queue_pkg;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One queue slot: the fetch address and the word returned for it
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {pc, inst} pairs. Flush wins over push
// and pop so a redirect always leaves the queue empty on the next edge.
module if_fetch_queue_fetch_fifo
   import if_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fetch_entry_t             push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   fetch_entry_t       mem_q [DEPTH];
   fetch_entry_t       mem_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic               push_ok;
   logic               pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];

   // Pushes into a full queue and pops from an empty one are ignored.
   assign push_ok = push && !full  && !flush;
   assign pop_ok  = pop  && !empty && !flush;

   // Next pointer/count state; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Next storage contents: only the tail slot changes, and only on a push
   always_comb begin
      mem_d = mem_q;
      if (push_ok) mem_d[wr_ptr_q] = push_data;
   end

   // Control state with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are qualified by count so no reset is needed
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues sequential fetches on the IAD/IREQ bus,
// buffers returned words with their PC, and redirects on taken branches.
// A request the bus cannot abort is finished in DISCARD and its data dropped.
module if_fetch_queue
   import if_fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [31:0]              IAD,
   output logic                     IREQ,
   input  logic [31:0]              IDT,
   input  logic                     ACKI_n,
   input  logic                     redirect,
   input  logic [31:0]              redirect_addr,
   input  logic                     inst_ready,
   output logic                     inst_valid,
   output logic [31:0]              inst,
   output logic [31:0]              inst_pc,
   output logic [31:0]              inst_pc4,
   output logic [$clog2(DEPTH):0]   queue_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e     state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      disc_addr_q, disc_addr_d;

   logic             ack;
   logic             pop_fire;
   logic [31:0]      target;
   logic [CNT_W-1:0] count_after;
   logic             fifo_push;
   logic             fifo_flush;
   logic             fifo_full;
   logic             fifo_empty;
   fetch_entry_t     fifo_head;
   fetch_entry_t     push_entry;
   logic             unused_addr_lsb;

   assign ack             = !ACKI_n;
   assign pop_fire        = inst_valid && inst_ready;
   assign target          = {redirect_addr[31:2], 2'b00};
   assign unused_addr_lsb = ^redirect_addr[1:0];
   assign push_entry      = '{pc: fetch_pc_q, inst: IDT};

   // Occupancy after a push in this cycle, accounting for a concurrent pop
   assign count_after = queue_count + CNT_W'(1) - CNT_W'(pop_fire);

   if_fetch_queue_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_entry),
      .pop       (pop_fire),
      .flush     (fifo_flush),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (queue_count),
      .head      (fifo_head)
   );

   // Head presentation; an empty queue shows a NOP at PC 0
   assign inst_valid = !fifo_empty;
   assign inst       = fifo_empty ? NOP_INST : fifo_head.inst;
   assign inst_pc    = fifo_empty ? 32'h0   : fifo_head.pc;
   assign inst_pc4   = inst_pc + 32'd4;

   // Fetch sequencer: next state, fetch address, bus outputs, queue control
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      disc_addr_d = disc_addr_q;
      fifo_push   = 1'b0;
      fifo_flush  = 1'b0;
      IREQ        = 1'b0;
      IAD         = fetch_pc_q;
      case (state_q)
         IDLE: begin
            if (redirect) begin
               fifo_flush = 1'b1;
               fetch_pc_d = target;
               state_d    = REQ;
            end else if (!fifo_full) begin
               state_d = REQ;
            end
         end
         REQ: begin
            IREQ = 1'b1;
            IAD  = fetch_pc_q;
            if (redirect) begin
               // Wrong-path data acked this cycle is simply not pushed
               fifo_flush = 1'b1;
               fetch_pc_d = target;
               if (ack) begin
                  state_d = REQ;
               end else begin
                  disc_addr_d = fetch_pc_q;
                  state_d     = DISCARD;
               end
            end else if (ack) begin
               fifo_push  = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = (count_after < CNT_W'(DEPTH)) ? REQ : IDLE;
            end
         end
         DISCARD: begin
            // The old request stays on the bus until the memory answers it
            IREQ = 1'b1;
            IAD  = disc_addr_q;
            if (redirect) begin
               fifo_flush = 1'b1;
               fetch_pc_d = target;
            end
            if (ack) state_d = REQ;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Sequencer registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         fetch_pc_q  <= RESET_PC;
         disc_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         disc_addr_q <= disc_addr_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a simple wait-state memory model.
// Returned instruction word for address A is ~A.
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] IAD;
   logic        IREQ;
   logic [31:0] IDT;
   logic        ACKI_n;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        inst_ready;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pc4;
   logic [2:0]  queue_count;

   int n_tests = 0;
   int n_fail  = 0;
   int mem_wait = 0;
   int wait_cnt = 0;

   always #5 clk = ~clk;

   if_fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .IAD           (IAD),
      .IREQ          (IREQ),
      .IDT           (IDT),
      .ACKI_n        (ACKI_n),
      .redirect      (redirect),
      .redirect_addr (redirect_addr),
      .inst_ready    (inst_ready),
      .inst_valid    (inst_valid),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .inst_pc4      (inst_pc4),
      .queue_count   (queue_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: memory answers after mem_wait idle cycles, then sample at edge+1
   task automatic step();
      if (IREQ) begin
         if (wait_cnt >= mem_wait) begin
            ACKI_n = 1'b0;
            IDT    = ~IAD;
         end else begin
            ACKI_n = 1'b1;
            IDT    = 32'hDEAD_BEEF;
            wait_cnt++;
         end
      end else begin
         ACKI_n = 1'b1;
      end
      @(posedge clk);
      if (!ACKI_n) wait_cnt = 0;
      #1;
      ACKI_n   = 1'b1;
      redirect = 1'b0;
   endtask

   task automatic apply_reset();
      rst           = 1'b0;
      ACKI_n        = 1'b1;
      IDT           = 32'h0;
      redirect      = 1'b0;
      redirect_addr = 32'h0;
      wait_cnt      = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      rst           = 1'b0;
      ACKI_n        = 1'b1;
      IDT           = 32'h0;
      redirect      = 1'b0;
      redirect_addr = 32'h0;
      inst_ready    = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ireq",  IREQ,        32'h0);
      chk("rst_iad",   IAD,         32'h0);
      chk("rst_valid", inst_valid,  32'h0);
      chk("rst_inst",  inst,        32'h0000_0013);
      chk("rst_pc",    inst_pc,     32'h0);
      chk("rst_pc4",   inst_pc4,    32'h4);
      chk("rst_count", queue_count, 32'h0);
      rst = 1'b1;

      // Zero-wait streaming, one instruction per cycle
      mem_wait = 0;
      step();
      chk("t1_ireq_first",  IREQ,       32'h1);
      chk("t1_iad_first",   IAD,        32'h0);
      chk("t1_valid_first", inst_valid, 32'h0);
      for (int e = 2; e <= 7; e++) begin
         step();
         chk($sformatf("t1_iad_e%0d", e),   IAD,         32'(4 * (e - 1)));
         chk($sformatf("t1_pc_e%0d", e),    inst_pc,     32'(4 * (e - 2)));
         chk($sformatf("t1_inst_e%0d", e),  inst,        ~32'(4 * (e - 2)));
         chk($sformatf("t1_pc4_e%0d", e),   inst_pc4,    32'(4 * (e - 1)));
         chk($sformatf("t1_valid_e%0d", e), inst_valid,  32'h1);
         chk($sformatf("t1_cnt_e%0d", e),   queue_count, 32'h1);
      end

      // Two wait states: address held three cycles, each word seen once
      apply_reset();
      mem_wait = 2;
      for (int e = 1; e <= 13; e++) begin
         int c;
         logic v;
         step();
         c = e - 1;
         v = (c >= 3) && (c % 3 == 0);
         chk($sformatf("t2_iad_e%0d", e),   IAD,         32'(4 * (c / 3)));
         chk($sformatf("t2_valid_e%0d", e), inst_valid,  {31'h0, v});
         chk($sformatf("t2_cnt_e%0d", e),   queue_count, {31'h0, v});
         if (v) chk($sformatf("t2_pc_e%0d", e), inst_pc, 32'(4 * (c / 3 - 1)));
      end

      // ID stall: queue fills to DEPTH, requests stop, then drain in order
      apply_reset();
      mem_wait   = 0;
      inst_ready = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         step();
         chk($sformatf("t3_cnt_e%0d", e),  queue_count, 32'((e - 1 > 4) ? 4 : e - 1));
         chk($sformatf("t3_ireq_e%0d", e), IREQ,        32'((e < 5) ? 1 : 0));
      end
      chk("t3_head_pc",    inst_pc,    32'h0);
      chk("t3_head_valid", inst_valid, 32'h1);
      inst_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("t3_drain_pc%0d", k),   inst_pc,     32'(4 * k));
         chk($sformatf("t3_drain_inst%0d", k), inst,        ~32'(4 * k));
         chk($sformatf("t3_drain_cnt%0d", k),  queue_count, 32'((k == 1) ? 3 : 2));
      end

      // Redirect while a request is in wait states
      apply_reset();
      mem_wait   = 0;
      inst_ready = 1'b1;
      repeat (5) step();
      chk("t4_iad_pre", IAD, 32'h10);
      mem_wait      = 2;
      redirect      = 1'b1;
      redirect_addr = 32'h0000_0103;
      step();
      chk("t4_disc_ireq",  IREQ,        32'h1);
      chk("t4_disc_iad",   IAD,         32'h10);
      chk("t4_disc_cnt",   queue_count, 32'h0);
      chk("t4_disc_valid", inst_valid,  32'h0);
      step();
      chk("t4_disc_iad2",  IAD,         32'h10);
      step();
      chk("t4_tgt_iad",    IAD,         32'h100);
      chk("t4_drop_cnt",   queue_count, 32'h0);
      chk("t4_drop_valid", inst_valid,  32'h0);
      mem_wait = 0;
      step();
      chk("t4_first_valid", inst_valid, 32'h1);
      chk("t4_first_pc",    inst_pc,    32'h100);
      chk("t4_first_inst",  inst,       ~32'h100);
      chk("t4_first_pc4",   inst_pc4,   32'h104);
      chk("t4_next_iad",    IAD,        32'h104);

      // Redirect coincident with an ack and a pop
      redirect      = 1'b1;
      redirect_addr = 32'h0000_0200;
      step();
      chk("t5_cnt",   queue_count, 32'h0);
      chk("t5_valid", inst_valid,  32'h0);
      chk("t5_inst",  inst,        32'h0000_0013);
      chk("t5_iad",   IAD,         32'h200);
      chk("t5_ireq",  IREQ,        32'h1);
      step();
      chk("t5_first_pc", inst_pc,     32'h200);
      chk("t5_first_cnt", queue_count, 32'h1);

      // fetch_pc and inst_pc4 wrap at 2^32
      redirect      = 1'b1;
      redirect_addr = 32'hFFFF_FFFF;
      step();
      chk("t7_iad_top", IAD, 32'hFFFF_FFFC);
      step();
      chk("t7_pc_top",  inst_pc,  32'hFFFF_FFFC);
      chk("t7_pc4_wrap", inst_pc4, 32'h0);
      chk("t7_iad_wrap", IAD,     32'h0);

      // Reset asserted mid-wait-state
      step();
      chk("t6_iad_pre", IAD, 32'h4);
      mem_wait = 2;
      step();
      chk("t6_wait_iad",  IAD,  32'h4);
      chk("t6_wait_ireq", IREQ, 32'h1);
      #3;
      rst = 1'b0;
      #1;
      chk("t6_rst_ireq",  IREQ,        32'h0);
      chk("t6_rst_iad",   IAD,         32'h0);
      chk("t6_rst_valid", inst_valid,  32'h0);
      chk("t6_rst_inst",  inst,        32'h0000_0013);
      chk("t6_rst_pc",    inst_pc,     32'h0);
      chk("t6_rst_pc4",   inst_pc4,    32'h4);
      chk("t6_rst_cnt",   queue_count, 32'h0);
      // The late ack arrives while reset is held and must be ignored
      ACKI_n = 1'b0;
      IDT    = ~32'h4;
      @(posedge clk);
      #1;
      ACKI_n   = 1'b1;
      wait_cnt = 0;
      chk("t6_late_ack_cnt", queue_count, 32'h0);
      rst      = 1'b1;
      mem_wait = 0;
      step();
      chk("t6_restart_ireq", IREQ, 32'h1);
      chk("t6_restart_iad",  IAD,  32'h0);
      step();
      chk("t6_restart_pc",    inst_pc,    32'h0);
      chk("t6_restart_valid", inst_valid, 32'h1);
      chk("t6_restart_iad2",  IAD,        32'h4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
